// File: rtl/draw_scheduler.sv
// Arbitrates N_REQ requesters onto their draw engines and muxes the owner's pixel port to the VGA adapter.
// Optional macro SCHED_ROUND_ROBIN_EN: round-robin arbitration; when undefined, fixed priority (lowest index wins).
module draw_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 40000,
  parameter int TW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   eng_start,
  input  logic [N_REQ-1:0]   eng_done,
  input  logic [N_REQ-1:0]   eng_writeEn,
  input  logic [8*N_REQ-1:0] eng_x,
  input  logic [7*N_REQ-1:0] eng_y,
  input  logic [8*N_REQ-1:0] eng_colour,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [7:0]         vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               err
);
  localparam int            WW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q, win_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_oh;
  logic [WW-1:0]    pick_off;
  logic [WW-1:0]    pick_idx;
  logic             pick_valid;
  logic             drawing;
  logic             owned;
  logic             own_done;
  logic             timeout_hit;

`ifdef SCHED_ROUND_ROBIN_EN
  logic [WW-1:0]      ptr_q, ptr_d;
  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] req_rot;
  logic [WW:0]        rr_sum;

  // Rotate requests so bit 0 is the requester just after the last winner.
  assign req_dbl  = {req, req};
  assign req_rot  = req_dbl >> ptr_q;
  assign cand     = req_rot[N_REQ-1:0];
  assign rr_sum   = {1'b0, ptr_q} + {1'b0, pick_off};
  assign pick_idx = (rr_sum >= (WW+1)'(N_REQ)) ? WW'(rr_sum - (WW+1)'(N_REQ))
                                                : rr_sum[WW-1:0];
`else
  assign cand     = req;
  assign pick_idx = pick_off;
`endif

  always_comb begin
    pick_valid = |cand;
    pick_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand[k]) pick_off = WW'(k);
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
    assign win_oh[gi] = (win_q == WW'(gi));
  end

  assign drawing     = (state_q == S_START) || (state_q == S_RUN);
  assign owned       = drawing || (state_q == S_RELEASE);
  assign own_done    = |(eng_done & win_oh);
  assign timeout_hit = (cnt_q == TIMEOUT_CNT);

  assign grant     = owned ? win_oh : '0;
  assign eng_start = drawing ? win_oh : '0;
  assign ack       = (state_q == S_ACK) ? win_oh : '0;
  assign busy      = (state_q != S_IDLE);
  // A completion seen in the same cycle as the limit counts as a normal finish.
  assign err       = drawing && timeout_hit && !((state_q == S_RUN) && own_done);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
`ifdef SCHED_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + TW'(1);
        if (timeout_hit) begin
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end else if (cnt_q == TW'(1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + TW'(1);
        if (own_done) begin
          state_d = S_RELEASE;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = abort_q ? S_IDLE : S_ACK;
`ifdef SCHED_ROUND_ROBIN_EN
        if (abort_q) ptr_d = (win_q == WW'(N_REQ - 1)) ? '0 : win_q + WW'(1);
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef SCHED_ROUND_ROBIN_EN
        ptr_d   = (win_q == WW'(N_REQ - 1)) ? '0 : win_q + WW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

`ifdef SCHED_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // Pixel port follows the owner only; plotting is allowed while the engine is started.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        vga_x      = eng_x[8*i +: 8];
        vga_y      = eng_y[7*i +: 7];
        vga_colour = eng_colour[8*i +: 8];
      end
    end
    vga_plot = drawing && (|(eng_writeEn & win_oh));
  end

endmodule
